ex_cloz_ctrl: RTL and testbench
===============================

Name: ex_cloz_ctrl

Overview:
- EX-stage sequencer for the multi-cycle count-ones/count-zeros unit.
- Accepts CLO/CLZ ops from the EX pipeline and stalls EX while the unit iterates.
- Drives the unit's valid/end handshake, holds the result until writeback accepts it, and absorbs flushes without desynchronising the unit.
- Keeps a single-entry result cache so that repeating the same op/operand skips the unit.

Parameters:
TIMEOUT, 48, max RUN cycles without unit_ready_i before abort (must exceed unit latency, 33).
CACHE_EN, 1, 1 = enable the single-entry result cache; 0 = every op uses the unit.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
ex_valid_i  in  1  EX presents a multi-cycle op this cycle
ex_op_i  in  2  01=CLZ, 10=CLO, 00/11=no-op (ignored)
ex_opdata_i  in  32  operand
flush_i  in  1  squash the in-flight op
wb_allow_i  in  1  downstream accepts result this cycle
stall_o  out  1  freeze EX
res_valid_o  out  1  result presented
res_o  out  32  result
busy_o  out  1  state != IDLE
err_o  out  1  sticky timeout flag
unit_valid_o  out  1  unit count enable
unit_one_o  out  1  1 = count ones (CLO), 0 = count zeros (CLZ)
unit_opdata_o  out  32  latched operand
unit_end_o  out  1  one-cycle release pulse to unit
unit_ready_i  in  1  unit result ready
unit_result_i  in  32  unit result

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all outputs 0.
  - Cache valid bit cleared; watchdog cleared.
  - Latched op/operand cleared; err_o cleared.
- States: IDLE, RUN, DONE.
- Accept condition, in IDLE: ex_valid_i & ex_op_i in {01,10} & !flush_i. stall_o=1 combinationally in the accept cycle.
- Cache hit (accept cycle):
  - Hit = CACHE_EN & cache valid & op and operand equal the cached pair.
  - res_o loads the cached result; next state is DONE. The unit is untouched.
  - Latency: res_valid_o=1 one cycle after accept.
- Miss (accept cycle): latch op and operand into unit_one_o / unit_opdata_o; clear watchdog; next state is RUN.
- RUN:
  - unit_valid_o = !unit_ready_i, combinational. It is never high while ready is high, which keeps the unit's internal bit counter aligned.
  - stall_o=1; watchdog increments each cycle.
  - On unit_ready_i:
    - unit_end_o=1 for that cycle only.
    - Capture unit_result_i into res_o and write the cache (op, operand, result); the cache is written even if the op was flushed.
    - Next state is IDLE if the op was flushed, otherwise DONE.
- Flush during RUN:
  - Set an internal "killed" flag.
  - The unit keeps running to completion and is still released with unit_end_o; no result is presented.
  - stall_o stays 1 until the unit is released, so a new op cannot collide with the busy unit.
- Timeout:
  - Condition: watchdog == TIMEOUT-1 in RUN without unit_ready_i.
  - err_o set (sticky until reset); unit_end_o pulsed; res_o=0.
  - Next state is DONE, or IDLE if killed.
  - The cache is not written.
- DONE:
  - res_valid_o=1; res_o stable; stall_o = !wb_allow_i.
  - wb_allow_i=1: next state IDLE; res_valid_o drops the next cycle.
  - flush_i=1: next state IDLE with no delivery. flush wins over wb_allow_i when both are high.
- No new op is accepted outside IDLE. A back-to-back op is accepted in the IDLE cycle after DONE; ex_valid_i is held by the stalled EX.
- busy_o = (state != IDLE).
- Async reset mid-RUN: controller returns to IDLE immediately. The unit shares the reset, so no end handshake is needed.

Test Plan:
- Bench unit model: count of operand bits equal to unit_one_o; ready asserted 33 cycles after first valid; ready held until end.
- CLO, operand 0x0000FFFF, wb_allow_i=1 → unit_valid_o high for 33 cycles, exactly one unit_end_o pulse, res_o=16, res_valid_o for 1 cycle, stall_o low the cycle after.
- Repeat same CLO/0x0000FFFF → res_valid_o one cycle after accept, res_o=16, unit_valid_o never asserted. With CACHE_EN=0 → full 33-cycle run.
- CLZ 0xF0000000, flush_i pulsed 5 cycles into RUN → unit still gets a single unit_end_o, res_valid_o never asserts, cache then holds the CLZ/0xF0000000 result 28.
- DONE with wb_allow_i=0 for 4 cycles → res_o stable, stall_o=1 throughout. Then flush_i and wb_allow_i together → IDLE, no delivery.
- Model never asserts ready, TIMEOUT=48 → abort after 48 RUN cycles, err_o=1 sticky, res_o=0, unit_end_o pulsed once.
- rst low mid-RUN (asynchronous, between clock edges) → all outputs 0 immediately. After release, a new CLZ 0x00000000 returns 32.

Source files
------------

// File: rtl/ex_cloz_ctrl.sv
// rtl/ex_cloz_ctrl.sv - EX-stage sequencer for the multi-cycle CLO/CLZ unit
// Stalls EX while the unit iterates, owns the valid/end handshake and a one-entry result cache.
module ex_cloz_ctrl #(
  parameter int TIMEOUT  = 48,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic [1:0]  ex_op_i,
  input  logic [31:0] ex_opdata_i,
  input  logic        flush_i,
  input  logic        wb_allow_i,
  output logic        stall_o,
  output logic        res_valid_o,
  output logic [31:0] res_o,
  output logic        busy_o,
  output logic        err_o,
  output logic        unit_valid_o,
  output logic        unit_one_o,
  output logic [31:0] unit_opdata_o,
  output logic        unit_end_o,
  input  logic        unit_ready_i,
  input  logic [31:0] unit_result_i
);

  localparam int WW = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic          killed;
  logic [WW-1:0] wdog;
  logic          cache_vld;
  logic          cache_one;
  logic [31:0]   cache_data;
  logic [31:0]   cache_res;
  logic [31:0]   res_q;
  logic          err_q;
  logic          one_q;
  logic [31:0]  opdata_q;

  logic op_ok, req_one, accept, hit, timeout, kill_now;

  always_comb begin
    op_ok    = (ex_op_i == 2'b01) || (ex_op_i == 2'b10);
    req_one  = ex_op_i[1];
    accept   = (state == IDLE) && ex_valid_i && op_ok && !flush_i;
    hit      = (CACHE_EN != 1'b0) && cache_vld && (cache_one == req_one) &&
               (cache_data == ex_opdata_i);
    timeout  = (state == RUN) && !unit_ready_i && (wdog == WD_LAST);
    kill_now = killed || flush_i;
  end

  // valid is withheld while ready is up so the unit's bit counter never overruns
  assign unit_valid_o  = (state == RUN) && !unit_ready_i;
  assign unit_end_o    = (state == RUN) && (unit_ready_i || timeout);
  assign stall_o       = accept || (state == RUN) || ((state == DONE) && !wb_allow_i);
  assign res_valid_o   = (state == DONE);
  assign busy_o        = (state != IDLE);
  assign res_o         = res_q;
  assign err_o         = err_q;
  assign unit_one_o    = one_q;
  assign unit_opdata_o = opdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      killed     <= 1'b0;
      wdog       <= '0;
      cache_vld  <= 1'b0;
      cache_one  <= 1'b0;
      cache_data <= '0;
      cache_res  <= '0;
      res_q      <= '0;
      err_q      <= 1'b0;
      one_q      <= 1'b0;
      opdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            killed <= 1'b0;
            if (hit) begin
              res_q <= cache_res;
              state <= DONE;
            end else begin
              one_q    <= req_one;
              opdata_q <= ex_opdata_i;
              wdog     <= '0;
              state    <= RUN;
            end
          end
        end
        RUN: begin
          if (flush_i) killed <= 1'b1;
          wdog <= wdog + 1'b1;
          if (unit_ready_i) begin
            // a squashed op still refreshes the cache: the result is valid for that operand
            res_q      <= unit_result_i;
            cache_vld  <= 1'b1;
            cache_one  <= one_q;
            cache_data <= opdata_q;
            cache_res  <= unit_result_i;
            state      <= kill_now ? IDLE : DONE;
          end else if (timeout) begin
            err_q <= 1'b1;
            res_q <= '0;
            state <= kill_now ? IDLE : DONE;
          end
        end
        DONE: begin
          if (flush_i || wb_allow_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_cloz_ctrl.sv
// tb/tb_ex_cloz_ctrl.sv - directed/random bench for ex_cloz_ctrl with unit and cache models
// A second instance with the cache disabled shares all stimulus.
module tb_ex_cloz_ctrl;

  localparam int TIMEOUT = 48;
  localparam int LAT     = 33;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0;
  logic [1:0]  ex_op = 2'b00;
  logic [31:0] ex_data = '0;
  logic        flush = 1'b0;
  logic        wb_allow = 1'b1;
  logic        never_ready = 1'b0;

  logic        stall0, rv0, busy0, err0, uv0, uone0, uend0, urdy0;
  logic [31:0] res0, udata0, ures0;
  logic        stall1, rv1, busy1, err1, uv1, uone1, uend1, urdy1;
  logic [31:0] res1, udata1, ures1;
  int          cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] pop(input logic [31:0] d, input logic one);
    logic [31:0] n = '0;
    for (int i = 0; i < 32; i++) if (d[i] == one) n++;
    return n;
  endfunction

  ex_cloz_ctrl #(.TIMEOUT(TIMEOUT), .CACHE_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .ex_valid_i(ex_valid), .ex_op_i(ex_op), .ex_opdata_i(ex_data),
    .flush_i(flush), .wb_allow_i(wb_allow), .stall_o(stall0), .res_valid_o(rv0), .res_o(res0),
    .busy_o(busy0), .err_o(err0), .unit_valid_o(uv0), .unit_one_o(uone0),
    .unit_opdata_o(udata0), .unit_end_o(uend0), .unit_ready_i(urdy0), .unit_result_i(ures0));

  ex_cloz_ctrl #(.TIMEOUT(TIMEOUT), .CACHE_EN(1'b0)) dut_nc (
    .clk(clk), .rst(rst), .ex_valid_i(ex_valid), .ex_op_i(ex_op), .ex_opdata_i(ex_data),
    .flush_i(flush), .wb_allow_i(wb_allow), .stall_o(stall1), .res_valid_o(rv1), .res_o(res1),
    .busy_o(busy1), .err_o(err1), .unit_valid_o(uv1), .unit_one_o(uone1),
    .unit_opdata_o(udata1), .unit_end_o(uend1), .unit_ready_i(urdy1), .unit_result_i(ures1));

  // unit model: ready after LAT valid cycles, held until the end pulse
  assign ures0 = urdy0 ? pop(udata0, uone0) : '0;
  assign ures1 = urdy1 ? pop(udata1, uone1) : '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      urdy0 <= 1'b0; cnt0 <= 0; urdy1 <= 1'b0; cnt1 <= 0;
    end else begin
      if (uend0) begin urdy0 <= 1'b0; cnt0 <= 0; end
      else if (uv0) begin cnt0 <= cnt0 + 1; if (cnt0 == LAT - 1 && !never_ready) urdy0 <= 1'b1; end
      if (uend1) begin urdy1 <= 1'b0; cnt1 <= 0; end
      else if (uv1) begin cnt1 <= cnt1 + 1; if (cnt1 == LAT - 1 && !never_ready) urdy1 <= 1'b1; end
    end
  end

  // reference cache: last completed unit run
  logic        m_vld = 1'b0;
  logic [1:0]  m_op;
  logic [31:0] m_data, m_res;

  int          r_lat, r_vcnt, r_vcnt1, r_ecnt, r_rv, r_deliv, r_stallbad, r_unstable, r_bound;
  logic [31:0] r_res;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] d);
    @(negedge clk);
    ex_valid = 1'b1; ex_op = op; ex_data = d;
    #1 chk("accept_stall", {31'b0, stall0}, 32'd1);
  endtask

  task automatic run(input int flush_at, input int hold);
    bit fin = 0, rel = 0;
    r_lat = 0; r_vcnt = 0; r_vcnt1 = 0; r_ecnt = 0; r_rv = 0; r_deliv = 0;
    r_stallbad = 0; r_unstable = 0; r_res = '0; r_bound = 0;
    wb_allow = (hold == 0);
    for (int k = 1; k <= 200 && !fin; k++) begin
      @(negedge clk);
      ex_valid = 1'b0;
      flush = (k == flush_at);
      if (rel) begin flush = 1'b1; wb_allow = 1'b1; rel = 0; end
      #1;
      if (uv0) r_vcnt++;
      if (uv1) r_vcnt1++;
      if (uend0) r_ecnt++;
      if (uv0 && urdy0) r_stallbad++;
      if (busy0 && !rv0 && !stall0) r_stallbad++;
      if (rv0 && !wb_allow && !stall0) r_stallbad++;
      if (rv0) begin
        if (r_rv == 0) begin r_lat = k; r_res = res0; end
        else if (res0 !== r_res) r_unstable++;
        r_rv++;
        if (wb_allow && !flush) r_deliv++;
        if (hold > 0 && r_rv == hold) rel = 1;
      end
      if (!busy0 && !busy1) fin = 1;
    end
    flush = 1'b0;
    if (!fin) r_bound = 1;
    chk("cycle_bound", r_bound, 0);
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] d);
    bit h = m_vld && (m_op == op) && (m_data == d);
    logic [31:0] exp_res = h ? m_res : pop(d, op[1]);
    issue(op, d);
    run(0, 0);
    chk("latency",   r_lat,   h ? 1 : LAT + 2);
    chk("valid_cyc", r_vcnt,  h ? 0 : LAT);
    chk("end_pulse", r_ecnt,  h ? 0 : 1);
    chk("result",    r_res,   exp_res);
    chk("delivered", r_deliv, 1);
    chk("stall_ok",  r_stallbad, 0);
    chk("nocache_valid_cyc", r_vcnt1, LAT);
    if (!h) begin m_vld = 1'b1; m_op = op; m_data = d; m_res = exp_res; end
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] d;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", stall0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_res_valid", rv0, 0);
    chk("rst_res", res0, 0);
    chk("rst_err", err0, 0);
    chk("rst_unit_valid", uv0, 0);
    chk("rst_unit_end", uend0, 0);
    chk("rst_unit_data", udata0, 0);
    @(negedge clk); rst = 1'b1;

    // no-op encodings are ignored
    @(negedge clk); ex_valid = 1'b1; ex_op = 2'b11;
    #1 chk("noop_stall", stall0, 0);
    @(negedge clk); ex_valid = 1'b0;
    #1 chk("noop_busy", busy0, 0);

    // first CLO runs the unit, the repeat hits the cache
    do_op(2'b10, 32'h0000FFFF);
    chk("clo_res16", r_res, 16);
    chk("rv_one_cycle", r_rv, 1);
    chk("stall_after", stall0, 0);
    do_op(2'b10, 32'h0000FFFF);
    chk("hit_res16", r_res, 16);

    // flush five cycles into RUN: unit released once, nothing delivered, cache still written
    issue(2'b01, 32'hF0000000);
    run(5, 0);
    chk("kill_valid_cyc", r_vcnt, LAT);
    chk("kill_end_pulse", r_ecnt, 1);
    chk("kill_no_rv", r_rv, 0);
    m_vld = 1'b1; m_op = 2'b01; m_data = 32'hF0000000; m_res = 32'd28;
    do_op(2'b01, 32'hF0000000);
    chk("kill_cache28", r_res, 28);

    // DONE held four cycles, then flush and wb_allow together
    d = m_data ^ 32'h1234_5678;
    issue(2'b10, d);
    run(0, 4);
    chk("hold_rv_cycles", r_rv, 5);
    chk("hold_stable", r_unstable, 0);
    chk("hold_stall", r_stallbad, 0);
    chk("hold_no_deliv", r_deliv, 0);
    chk("hold_res", r_res, pop(d, 1'b1));
    m_vld = 1'b1; m_op = 2'b10; m_data = d; m_res = pop(d, 1'b1);

    for (int i = 0; i < 8; i++) begin
      if (m_vld && $urandom_range(0, 2) == 0) begin op = m_op; d = m_data; end
      else begin op = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01; d = $urandom(); end
      do_op(op, d);
    end

    // watchdog abort with a unit that never becomes ready
    never_ready = 1'b1;
    d = m_data ^ 32'h0000_0001;
    issue(2'b01, d);
    run(0, 0);
    never_ready = 1'b0;
    chk("to_valid_cyc", r_vcnt, TIMEOUT);
    chk("to_end_pulse", r_ecnt, 1);
    chk("to_latency", r_lat, TIMEOUT + 1);
    chk("to_res0", r_res, 0);
    chk("to_err", err0, 1);
    do_op(2'b10, m_data ^ 32'h0000_0002);
    chk("err_sticky", err0, 1);

    // asynchronous reset between clock edges mid-RUN
    issue(2'b10, 32'hA5A5_0F0F);
    repeat (10) begin @(negedge clk); ex_valid = 1'b0; end
    #1 chk("midrun_busy", busy0, 1);
    #1 rst = 1'b0;
    #1;
    chk("ar_busy", busy0, 0);
    chk("ar_unit_valid", uv0, 0);
    chk("ar_unit_end", uend0, 0);
    chk("ar_stall", stall0, 0);
    chk("ar_res_valid", rv0, 0);
    chk("ar_res", res0, 0);
    chk("ar_err", err0, 0);
    chk("ar_unit_data", udata0, 0);
    m_vld = 1'b0;
    @(negedge clk); rst = 1'b1;
    do_op(2'b01, 32'h0000_0000);
    chk("clz0_32", r_res, 32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
